basic_system_ram_test_master: RTL and testbench

- Avalon-MM master that exercises a 32-bit word-addressed on-chip RAM slave.
- On `start`, writes a pseudo-random LFSR pattern over a region, then reads the region back and compares each word.
- Reports pass/fail, error count and first failing address.
- Sits on the system interconnect as a built-in self-test master for the on-chip RAM, driven by a control CSR or by pins.

---
 rtl/basic_system_ram_test_master.sv | 181 ++++++++++++++++++
 tb/tb_basic_system_ram_test_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/basic_system_ram_test_master.sv
// rtl/basic_system_ram_test_master.sv - Avalon-MM built-in self-test master for a 32-bit word-addressed RAM
module basic_system_ram_test_master #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int ERR_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [31:0]           seed,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic [3:0]            avm_byteenable,
    output logic                  avm_chipselect,
    output logic                  avm_write,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [ADDR_WIDTH-1:0] first_error_address
);

    localparam logic [31:0]         LFSR_MASK = 32'h80200003;
    localparam logic [ADDR_WIDTH:0] IDX_ONE   = 1;
    localparam logic [ERR_WIDTH-1:0] ERR_ONE  = 1;
    localparam logic [ERR_WIDTH-1:0] ERR_MAX  = '1;
    localparam logic [2:0]          LAT_LAST  = 3'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [31:0]           seed_q, seed_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [2:0]            lat_q, lat_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
    logic                  pass_q, pass_d;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  last_word;
    logic                  accept;
    logic [31:0]           lfsr_next;
    logic [31:0]           seed_eff;

    assign word_addr = base_q + idx_q[ADDR_WIDTH-1:0];
    assign last_word = (idx_q == (len_q - IDX_ONE));
    assign accept    = avm_chipselect & ~avm_waitrequest;
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
    assign seed_eff  = (seed == 32'h0) ? 32'h1 : seed;

    // Bus outputs come straight from held registers, so they stay stable under waitrequest.
    always_comb begin
        avm_chipselect      = (state_q == S_WRITE) || (state_q == S_READ_REQ);
        avm_write           = (state_q == S_WRITE);
        avm_byteenable      = avm_chipselect ? 4'b1111 : 4'b0000;
        avm_address         = avm_chipselect ? word_addr : '0;
        avm_writedata       = avm_write ? lfsr_q : 32'h0;
        busy                = (state_q == S_WRITE) || (state_q == S_READ_REQ) ||
                              (state_q == S_READ_WAIT);
        done                = (state_q == S_DONE);
        pass                = pass_q;
        error_count         = err_q;
        first_error_address = ferr_q;
    end

    // Next-state logic: test sequencing, pattern generation and read-back comparison.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        seed_d  = seed_q;
        lfsr_d  = lfsr_q;
        lat_d   = lat_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_address;
                    len_d   = length;
                    seed_d  = seed_eff;
                    lfsr_d  = seed_eff;
                    idx_d   = '0;
                    lat_d   = '0;
                    err_d   = '0;
                    ferr_d  = '0;
                    pass_d  = 1'b0;
                    state_d = (length == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    if (last_word) begin
                        idx_d   = '0;
                        lfsr_d  = seed_q;
                        state_d = S_READ_REQ;
                    end else begin
                        idx_d  = idx_q + IDX_ONE;
                        lfsr_d = lfsr_next;
                    end
                end
            end
            S_READ_REQ: begin
                if (accept) begin
                    lat_d   = 3'd1;
                    state_d = S_READ_WAIT;
                end
            end
            S_READ_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    if (avm_readdata != lfsr_q) begin
                        if (err_q == '0) begin
                            ferr_d = word_addr;
                        end
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_ONE;
                        end
                    end
                    lfsr_d  = lfsr_next;
                    idx_d   = idx_q + IDX_ONE;
                    state_d = last_word ? S_DONE : S_READ_REQ;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The verdict lands on the same edge that enters DONE so it is valid with the done pulse.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            pass_d = (err_d == '0);
        end
    end

    // State register with synchronous reset; reset also aborts any test in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            seed_q  <= '0;
            lfsr_q  <= '0;
            lat_q   <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            seed_q  <= seed_d;
            lfsr_q  <= lfsr_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            pass_q  <= pass_d;
        end
    end

endmodule

// File: tb/tb_basic_system_ram_test_master.sv
// tb/tb_basic_system_ram_test_master.sv - directed self-checking bench for the RAM test master
module tb_basic_system_ram_test_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_address;
    logic [10:0] length;
    logic [31:0] seed;
    logic [9:0]  avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] error_count;
    logic [9:0]  first_error_address;

    basic_system_ram_test_master #(
        .ADDR_WIDTH(10), .READ_LATENCY(1), .ERR_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_address(base_address),
        .length(length), .seed(seed), .avm_address(avm_address),
        .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .first_error_address(first_error_address)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    // RAM slave model with one-cycle read latency, optional corruption and random stalls.
    logic [31:0] mem [0:1023];
    bit          corrupt   = 0;
    bit          rand_wait = 0;
    logic [9:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    logic [9:0]  rd_addr [$];
    int          cs_cycles  = 0;
    int          stall_viol = 0;
    int          overlap    = 0;
    bit          stalled    = 0;
    logic [50:0] saved;

    always @(posedge clk) begin
        if (stalled && ({avm_address, avm_write, avm_writedata, avm_chipselect, avm_byteenable[3:0], 4'b0} != saved))
            stall_viol++;
        stalled = avm_chipselect && avm_waitrequest;
        saved   = {avm_address, avm_write, avm_writedata, avm_chipselect, avm_byteenable[3:0], 4'b0};
        if (avm_chipselect) cs_cycles++;
        if (!avm_chipselect && avm_write) overlap++;
        if (avm_chipselect && !avm_waitrequest) begin
            if (avm_write) begin
                mem[avm_address] = avm_writedata;
                wr_addr.push_back(avm_address);
                wr_data.push_back(avm_writedata);
            end else begin
                rd_addr.push_back(avm_address);
                avm_readdata <= mem[avm_address] ^
                    ((corrupt && (avm_address == 10'd5 || avm_address == 10'd9)) ? 32'h1 : 32'h0);
            end
        end
    end

    always @(negedge clk) avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        rd_addr.delete();
        cs_cycles  = 0;
        stall_viol = 0;
    endtask

    // Returns the inclusive cycle count from the start cycle to the done cycle.
    task automatic run_test(input logic [9:0] b, input logic [10:0] l, input logic [31:0] s,
                            input bit pulse_mid, output int cyc);
        clear_logs();
        @(negedge clk);
        base_address = b;
        length       = l;
        seed         = s;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 2;
        if (l != 0) check("busy_after_start", busy, 1);
        while (!done && cyc < 8000) begin
            if (pulse_mid && (cyc % 7 == 0)) begin
                start        = 1'b1;
                length       = 11'd3;
                base_address = 10'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
    endtask

    int cyc;
    logic [31:0] v;
    logic [31:0] exp1 [4];

    initial begin
        exp1[0] = 32'h00000001;
        exp1[1] = 32'h80200003;
        exp1[2] = 32'hC0300002;
        exp1[3] = 32'h60180001;
        avm_readdata = 32'h0;
        reset = 1'b1; start = 1'b0; base_address = '0; length = '0; seed = '0;
        repeat (3) @(negedge clk);
        check("rst_cs", avm_chipselect, 0);
        check("rst_be", avm_byteenable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", error_count, 0);
        check("rst_ferr", first_error_address, 0);
        check("rst_addr", avm_address, 0);
        reset = 1'b0;

        // Basic 4-word run from address 0 with seed 1.
        run_test(10'd0, 11'd4, 32'd1, 0, cyc);
        check("t1_cycles", cyc, 14);
        check("t1_pass", pass, 1);
        check("t1_err", error_count, 0);
        check("t1_nwr", wr_data.size(), 4);
        check("t1_nrd", rd_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_wdata%0d", i), wr_data[i], exp1[i]);
            check($sformatf("t1_waddr%0d", i), wr_addr[i], i);
            check($sformatf("t1_raddr%0d", i), rd_addr[i], i);
        end
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_pass_sticky", pass, 1);

        // Address wrap-around, seed 0 substituted by 1.
        run_test(10'd1022, 11'd4, 32'd0, 0, cyc);
        check("t2_pass", pass, 1);
        check("t2_nwr", wr_addr.size(), 4);
        check("t2_wdata0", wr_data[0], 32'h1);
        check("t2_waddr0", wr_addr[0], 1022);
        check("t2_waddr1", wr_addr[1], 1023);
        check("t2_waddr2", wr_addr[2], 0);
        check("t2_waddr3", wr_addr[3], 1);
        check("t2_raddr0", rd_addr[0], 1022);
        check("t2_raddr3", rd_addr[3], 1);

        // Corrupted reads at addresses 5 and 9.
        corrupt = 1;
        run_test(10'd0, 11'd16, 32'h12345678, 0, cyc);
        corrupt = 0;
        check("t3_err", error_count, 2);
        check("t3_ferr", first_error_address, 5);
        check("t3_pass", pass, 0);
        check("t3_cycles", cyc, 50);

        // Random stalls with stray start pulses.
        rand_wait = 1;
        run_test(10'd100, 11'd20, 32'hDEADBEEF, 1, cyc);
        rand_wait = 0;
        check("t4_stable", stall_viol, 0);
        check("t4_pass", pass, 1);
        check("t4_err", error_count, 0);
        check("t4_nwr", wr_data.size(), 20);
        check("t4_nrd", rd_addr.size(), 20);
        v = 32'hDEADBEEF;
        for (int i = 0; i < 20; i++) begin
            if (i < wr_data.size()) begin
                check($sformatf("t4_wdata%0d", i), wr_data[i], v);
                check($sformatf("t4_waddr%0d", i), wr_addr[i], 100 + i);
            end
            v = lfsr_step(v);
        end

        // Zero length.
        run_test(10'd7, 11'd0, 32'd5, 0, cyc);
        check("t5_cycles", cyc, 2);
        check("t5_cs", cs_cycles, 0);
        check("t5_pass", pass, 1);

        // Reset in READ_WAIT of a full-size test.
        corrupt = 1;
        clear_logs();
        @(negedge clk);
        base_address = 10'd0; length = 11'd1024; seed = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rd_addr.size() < 12 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_reached_read", rd_addr.size(), 12);
        check("t6_in_wait", {busy, avm_chipselect}, 2'b10);
        check("t6_err_pre", error_count, 2);
        reset = 1'b1;
        @(negedge clk);
        check("t6_cs", avm_chipselect, 0);
        check("t6_busy", busy, 0);
        check("t6_err", error_count, 0);
        check("t6_ferr", first_error_address, 0);
        reset = 1'b0;
        corrupt = 0;
        cs_cycles = 0;
        repeat (5) @(negedge clk);
        check("t6_quiet", cs_cycles, 0);
        run_test(10'd0, 11'd1024, 32'd3, 0, cyc);
        check("t6_full_cycles", cyc, 3074);
        check("t6_full_pass", pass, 1);
        check("t6_full_err", error_count, 0);
        check("t6_full_nwr", wr_data.size(), 1024);
        check("t6_full_nrd", rd_addr.size(), 1024);
        check("no_write_without_cs", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
